// File: rtl/moving_average.sv
// Streaming moving average over a 2**WIN_LOG2 sample window with one cycle of latency.
// Optional build macro MOVING_AVERAGE_ROUND_EN selects round-half-up instead of truncation.
module moving_average #(
  parameter int TDATA_WIDTH = 8,
  parameter int WIN_LOG2    = 2
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [TDATA_WIDTH-1:0] m_axis_tdata
);

  localparam int WINDOW = 1 << WIN_LOG2;
  localparam int SUM_W  = TDATA_WIDTH + WIN_LOG2;

  // Handshake: a transfer happens on a rising edge where valid && ready. The output
  // register may be refilled whenever it is empty or being drained in the same cycle,
  // so s_axis_tready depends only on m_axis_tvalid and m_axis_tready.
  logic signed [TDATA_WIDTH-1:0] history [WINDOW];
  logic [WIN_LOG2-1:0]           wr_ptr;
  logic signed [SUM_W-1:0]       sum;
  logic signed [SUM_W-1:0]       sum_next;
  logic signed [SUM_W-1:0]       new_ext;
  logic signed [SUM_W-1:0]       old_ext;
  logic [TDATA_WIDTH-1:0]        result;
  logic                          in_xfer;
  logic                          out_xfer;

  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign in_xfer       = s_axis_tvalid && s_axis_tready;
  assign out_xfer      = m_axis_tvalid && m_axis_tready;

  assign new_ext  = {{WIN_LOG2{s_axis_tdata[TDATA_WIDTH-1]}}, s_axis_tdata};
  assign old_ext  = {{WIN_LOG2{history[wr_ptr][TDATA_WIDTH-1]}}, history[wr_ptr]};
  assign sum_next = sum + new_ext - old_ext;

`ifdef MOVING_AVERAGE_ROUND_EN
  // One guard bit above the sum so adding the half-LSB bias can never wrap.
  localparam logic [SUM_W:0] ROUND_BIAS = (SUM_W + 1)'(1) << (WIN_LOG2 - 1);
  logic [SUM_W:0] rounded;
  assign rounded = {sum_next[SUM_W-1], sum_next} + ROUND_BIAS;
  assign result  = rounded[SUM_W-1:WIN_LOG2];
`else
  // Dropping the low WIN_LOG2 bits of a two's complement sum floors toward -inf.
  assign result = sum_next[SUM_W-1:WIN_LOG2];
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < WINDOW; i++) begin
        history[i] <= '0;
      end
      wr_ptr        <= '0;
      sum           <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (in_xfer) begin
      history[wr_ptr] <= s_axis_tdata;
      wr_ptr          <= wr_ptr + WIN_LOG2'(1);
      sum             <= sum_next;
      m_axis_tdata    <= result;
      m_axis_tvalid   <= 1'b1;
    end else if (out_xfer) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_moving_average.sv
// Directed bench for moving_average: a window-queue reference model checked every cycle,
// plus literal expectations for ramp, rounding, backpressure, wrap and mid-stream reset.
module tb_moving_average;

  localparam int TW  = 8;
  localparam int WL2 = 2;
  localparam int WIN = 1 << WL2;

  logic                 aclk = 1'b0;
  logic                 areset = 1'b1;
  logic                 s_tvalid = 1'b0;
  logic                 s_tready;
  logic signed [TW-1:0] s_tdata = '0;
  logic                 m_tvalid;
  logic                 m_tready = 1'b1;
  logic signed [TW-1:0] m_tdata;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int model_win[$];
  int exp_q[$];
  int out_log[$];
  int out_cyc[$];

  moving_average #(.TDATA_WIDTH(TW), .WIN_LOG2(WL2)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata)
  );

  // clock / cycle counter
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: mean of the last WIN accepted samples, empty slots counted as zero.
  function automatic int model_avg(input int s);
`ifdef MOVING_AVERAGE_ROUND_EN
    return (s + (WIN / 2)) >>> WL2;
`else
    return s >>> WL2;
`endif
  endfunction

  task automatic model_clear();
    model_win.delete();
    for (int i = 0; i < WIN; i++) model_win.push_back(0);
  endtask

  function automatic int model_push(input int v);
    int s;
    s = 0;
    void'(model_win.pop_front());
    model_win.push_back(v);
    foreach (model_win[i]) s += model_win[i];
    return model_avg(s);
  endfunction

  // scoreboard: checks every cycle away from the active edge
  always @(negedge aclk) begin
    if (areset) begin
      model_clear();
      exp_q.delete();
    end else begin
      chk("m_tvalid_vs_model", int'(m_tvalid), int'(exp_q.size() != 0));
      chk("s_tready_rule", int'(s_tready), int'(!m_tvalid || m_tready));
      if (exp_q.size() != 0) chk("m_tdata_vs_model", int'(m_tdata), exp_q[0]);
      if (m_tvalid && m_tready) begin
        out_log.push_back(int'(m_tdata));
        out_cyc.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_tvalid && s_tready) exp_q.push_back(model_push(int'(s_tdata)));
    end
  end

  // driver tasks
  task automatic send(input int v);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = TW'(v);
    @(negedge aclk);
    while (!s_tready && n < 50) begin
      n++;
      @(negedge aclk);
    end
    if (!s_tready) chk("send_timeout", 0, 1);
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    areset   = 1'b1;
    @(posedge aclk);
    #1;
    chk("reset_m_tvalid", int'(m_tvalid), 0);
    chk("reset_m_tdata", int'(m_tdata), 0);
    chk("reset_s_tready", int'(s_tready), 1);
    @(posedge aclk);
    #1;
    areset = 1'b0;
    out_log.delete();
    out_cyc.delete();
  endtask

  task automatic chk_log(input string name, input int exp[$]);
    chk({name, "_count"}, out_log.size(), exp.size());
    foreach (exp[i]) begin
      if (i < out_log.size()) chk(name, out_log[i], exp[i]);
    end
  endtask

  initial begin
    int e[$];

    // Ramp
    do_reset();
    m_tready = 1'b1;
    send(4); send(8); send(12); send(16); send(16);
    idle(3);
    e = '{1, 3, 6, 10, 13};
    chk_log("ramp", e);
    foreach (out_cyc[i]) if (i > 0) chk("ramp_latency", out_cyc[i] - out_cyc[i-1], 1);

    // Rounding
    do_reset();
    send(6);
    idle(3);
`ifdef MOVING_AVERAGE_ROUND_EN
    e = '{2};
`else
    e = '{1};
`endif
    chk_log("round_pos", e);
    do_reset();
    send(-1);
    idle(3);
`ifdef MOVING_AVERAGE_ROUND_EN
    e = '{0};
`else
    e = '{-1};
`endif
    chk_log("round_neg", e);

    // Backpressure with an output of 3 pending
    do_reset();
    m_tready = 1'b1;
    send(4);
    idle(2);
    m_tready = 1'b0;
    send(8);
    s_tvalid = 1'b1;
    s_tdata  = 8'sd12;
    repeat (5) begin
      @(negedge aclk);
      chk("bp_s_tready", int'(s_tready), 0);
      chk("bp_m_tvalid", int'(m_tvalid), 1);
      chk("bp_m_tdata_hold", int'(m_tdata), 3);
    end
    @(posedge aclk);
    #1;
    m_tready = 1'b1;
    send(12); send(16);
    idle(3);
    e = '{1, 3, 6, 10};
    chk_log("backpressure", e);

    // Throughput and extreme values
    do_reset();
    m_tready = 1'b1;
    repeat (12) send(-128);
    repeat (4) send(127);
    idle(3);
    chk("thru_count", out_log.size(), 16);
    if (out_log.size() == 16) begin
      chk("thru_first", out_log[0], -32);
      chk("thru_fill", out_log[3], -128);
      chk("thru_steady", out_log[11], -128);
`ifdef MOVING_AVERAGE_ROUND_EN
      chk("thru_mix", out_log[12], -64);
`else
      chk("thru_mix", out_log[12], -65);
`endif
      chk("thru_top", out_log[15], 127);
      for (int i = 1; i < 16; i++) chk("thru_rate", out_cyc[i] - out_cyc[i-1], 1);
    end

    // Mid-stream reset, with a sample offered during the reset pulse
    do_reset();
    send(4); send(8);
    s_tvalid = 1'b1;
    s_tdata  = 8'sd100;
    areset   = 1'b1;
    @(posedge aclk);
    #1;
    chk("mid_reset_m_tvalid", int'(m_tvalid), 0);
    chk("mid_reset_s_tready", int'(s_tready), 1);
    areset   = 1'b0;
    s_tvalid = 1'b0;
    out_log.delete();
    out_cyc.delete();
    idle(1);
    send(12);
    idle(3);
    e = '{3};
    chk_log("mid_reset", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/moving_average.md
MOVING_AVERAGE -- requirements
Module: moving_average

Interface
- REQ-001 SHALL have parameter TDATA_WIDTH, default 8: sample width in bits, signed two's complement, minimum 2.
- REQ-002 SHALL have parameter WIN_LOG2, default 2: log2 of window length, so WINDOW = 2**WIN_LOG2; minimum 1.
- REQ-003 SHALL have port aclk, input, 1: sole clock; all logic on rising edge.
- REQ-004 SHALL have port areset, input, 1: reset, synchronous, active-high.
- REQ-005 SHALL have port s_axis_tvalid, input, 1: upstream sample valid.
- REQ-006 SHALL have port s_axis_tready, output, 1: block accepts a sample this cycle.
- REQ-007 SHALL have port s_axis_tdata, input, TDATA_WIDTH: input sample.
- REQ-008 SHALL have port m_axis_tvalid, output, 1: averaged sample valid, feeding the decimator stage.
- REQ-009 SHALL have port m_axis_tready, input, 1: downstream accepts output.
- REQ-010 SHALL have port m_axis_tdata, output, TDATA_WIDTH: averaged sample.

Function
- REQ-011 SHALL hold a circular history of WINDOW samples, a write pointer of WIN_LOG2 bits, and a running sum of TDATA_WIDTH+WIN_LOG2 bits, all signed.
- REQ-012 SHALL define an input transfer as s_axis_tvalid && s_axis_tready, and an output transfer as m_axis_tvalid && m_axis_tready.
- REQ-013 SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready, combinationally; no combinational path from s_axis_tvalid to s_axis_tready.
- REQ-014 On input transfer, SHALL compute sum_next = sum + sign-extended new sample - sign-extended history[wr_ptr], write the new sample to history[wr_ptr], and increment wr_ptr.
- REQ-015 SHALL wrap wr_ptr from WINDOW-1 to 0.
- REQ-016 On input transfer, SHALL register m_axis_tdata = sum_next arithmetically shifted right by WIN_LOG2, keeping the low TDATA_WIDTH bits; m_axis_tvalid SHALL be 1 the next cycle, for a latency of 1 cycle.
- REQ-017 SHALL clear m_axis_tvalid on an output transfer with no simultaneous input transfer.
- REQ-018 On a simultaneous input and output transfer, SHALL load the new result and keep m_axis_tvalid = 1, giving full throughput of one sample per cycle.
- REQ-019 While m_axis_tvalid = 1 and m_axis_tready = 0, SHALL hold m_axis_tdata stable and leave history, sum and wr_ptr unchanged.
- REQ-020 SHALL emit an output for every input starting from the first one, with no warm-up suppression; unfilled history slots count as zero.
- REQ-021 Running sum SHALL never overflow, since the extra WIN_LOG2 bits cover the full window.

Reset
- REQ-022 On areset = 1 at a clock edge, SHALL clear all history entries, sum and wr_ptr to 0, set m_axis_tvalid = 0 and m_axis_tdata = 0.
- REQ-023 Reset SHALL take priority over any transfer in the same cycle; a pending output is discarded.
- REQ-024 During reset, s_axis_tready SHALL follow REQ-013, reading 1 because m_axis_tvalid = 0, but SHALL NOT accept data.

Configuration
- REQ-025 With macro MOVING_AVERAGE_ROUND_EN defined, SHALL add 2**(WIN_LOG2-1) to sum_next before the shift, giving round-half-up; the addition SHALL use one extra guard bit so it cannot wrap.
- REQ-026 Without MOVING_AVERAGE_ROUND_EN, SHALL truncate toward negative infinity as in REQ-016.

Verification (TDATA_WIDTH=8, WIN_LOG2=2)
- REQ-027 Ramp: after reset, send inputs 4, 8, 12, 16, 16 with m_axis_tready = 1 -> outputs 1, 3, 6, 10, 13, each one cycle after its input.
- REQ-028 Rounding: after reset, send a single input 6 -> output 1 without the macro, 2 with it; after reset, send a single input -1 -> output -1 without, 0 with.
- REQ-029 Backpressure: hold m_axis_tready = 0 with an output pending, value 3, while s_axis_tvalid = 1 for 5 cycles -> s_axis_tready = 0, m_axis_tdata stays 3, and the next outputs after release continue the ramp unchanged.
- REQ-030 Throughput and wrap: stream 12 inputs of -128, then 4 inputs of 127 with continuous ready -> one output per cycle; outputs reach -128, then 127 exactly on the 4th 127; no overflow.
- REQ-031 Mid-stream reset: after inputs 4, 8, pulse areset for 1 cycle, then send 12 -> m_axis_tvalid is 0 during reset, and the next output is 3, proving the history was cleared.
